// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes, coin values and the change FSM state type.
// Coin code 3 (QUARTER) is only produced when CHANGE_QUARTER_EN is defined.
package vm_pkg;

  localparam logic [1:0] PENNY   = 2'd0;
  localparam logic [1:0] NICKEL  = 2'd1;
  localparam logic [1:0] DIME    = 2'd2;
  localparam logic [1:0] QUARTER = 2'd3;

  localparam int unsigned VAL_NICKEL  = 5;
  localparam int unsigned VAL_DIME    = 10;
  localparam int unsigned VAL_QUARTER = 25;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Pennies are never dispensed, so they carry no payable value here.
  function automatic int unsigned coin_value(input logic [1:0] code);
    case (code)
      NICKEL:  return VAL_NICKEL;
      DIME:    return VAL_DIME;
      QUARTER: return VAL_QUARTER;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational coin picker: largest available coin not exceeding the remaining balance.
// Quarter support is compiled in with CHANGE_QUARTER_EN.
module coin_select
  import vm_pkg::*;
#(
  parameter int CENT_W = 8
) (
  input  logic [CENT_W-1:0] remaining,
  input  logic              dime_empty,
  input  logic              nickel_empty,
`ifdef CHANGE_QUARTER_EN
  input  logic              quarter_empty,
`endif
  output logic              found,
  output logic [1:0]        code,
  output logic [CENT_W-1:0] value
);

  // Later tests override earlier ones, so the last match is the highest priority coin.
  always_comb begin
    found = 1'b0;
    code  = PENNY;
    if (remaining >= CENT_W'(VAL_NICKEL) && !nickel_empty) begin
      found = 1'b1;
      code  = NICKEL;
    end
    if (remaining >= CENT_W'(VAL_DIME) && !dime_empty) begin
      found = 1'b1;
      code  = DIME;
    end
`ifdef CHANGE_QUARTER_EN
    if (remaining >= CENT_W'(VAL_QUARTER) && !quarter_empty) begin
      found = 1'b1;
      code  = QUARTER;
    end
`endif
  end

  assign value = CENT_W'(coin_value(code));

endmodule

// File: rtl/change_dispenser.sv
// Converts a refund amount into a stream of coin codes for the hopper, reporting unpaid cents.
// Defining CHANGE_QUARTER_EN adds the quarter_empty input and quarter dispensing.
//
// state  | meaning
// IDLE   | waiting for a refund request, req_ready high
// SELECT | choosing the next coin from remaining balance and empty flags
// ISSUE  | presenting one coin until the hopper takes it
// DONE   | done pulse with owed valid, then back to IDLE
module change_dispenser
  import vm_pkg::*;
#(
  parameter int CENT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [CENT_W-1:0] req_amount,
  output logic              req_ready,
  input  logic              dime_empty,
  input  logic              nickel_empty,
`ifdef CHANGE_QUARTER_EN
  input  logic              quarter_empty,
`endif
  output logic              coin_valid,
  output logic [1:0]        coin,
  input  logic              coin_ready,
  output logic              done,
  output logic [CENT_W-1:0] owed
);

  state_t              state;
  logic [CENT_W-1:0]   remaining;
  logic [CENT_W-1:0]   coin_val;
  logic [CENT_W-1:0]   rem_next;
  logic                sel_found;
  logic [1:0]          sel_code;
  logic [CENT_W-1:0]   sel_value;

  coin_select #(.CENT_W(CENT_W)) u_coin_select (
    .remaining    (remaining),
    .dime_empty   (dime_empty),
    .nickel_empty (nickel_empty),
`ifdef CHANGE_QUARTER_EN
    .quarter_empty(quarter_empty),
`endif
    .found        (sel_found),
    .code         (sel_code),
    .value        (sel_value)
  );

  // A coin is only chosen when remaining covers it, so this never wraps.
  assign rem_next = remaining - coin_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      coin_val   <= '0;
      req_ready  <= 1'b1;
      coin_valid <= 1'b0;
      coin       <= PENNY;
      done       <= 1'b0;
      owed       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            remaining <= req_amount;
            req_ready <= 1'b0;
            state     <= SELECT;
          end
        end
        SELECT: begin
          if (sel_found) begin
            coin       <= sel_code;
            coin_val   <= sel_value;
            coin_valid <= 1'b1;
            state      <= ISSUE;
          end else begin
            done  <= 1'b1;
            owed  <= remaining;
            state <= DONE;
          end
        end
        ISSUE: begin
          if (coin_ready) begin
            coin_valid <= 1'b0;
            remaining  <= rem_next;
            if (rem_next < CENT_W'(VAL_NICKEL)) begin
              done  <= 1'b1;
              owed  <= rem_next;
              state <= DONE;
            end else begin
              state <= SELECT;
            end
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Returns change to the customer by converting a refund amount in cents into a sequence of coin codes for the coin hopper. It sits downstream of the ticket vending FSM and drives coins out on the same 2-bit coin encoding the vending machine accepts: PENNY=0, NICKEL=1, DIME=2. It uses a valid/ready handshake on both sides and reports any amount it could not pay.

## Interface
- `CENT_W`, 8: width of amount and owed fields, in cents.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  refund request present.
- `req_amount`  in  CENT_W  refund amount in cents.
- `req_ready`  out  1  high only in IDLE.
- `dime_empty`  in  1  dime hopper exhausted.
- `nickel_empty`  in  1  nickel hopper exhausted.
- `coin_valid`  out  1  `coin` holds a coin to eject.
- `coin`  out  2  coin code; never PENNY while valid.
- `coin_ready`  in  1  hopper ejected the presented coin.
- `done`  out  1  one-cycle pulse at end of every request.
- `owed`  out  CENT_W  cents not paid; valid with `done`, held until next accept.

## Operation
- States:
  - IDLE: `req_ready`=1. Handshake `req_valid && req_ready` loads `remaining` = `req_amount`, then goes to SELECT.
  - SELECT: picks a coin from the registered `remaining` and the empty flags sampled this cycle. Priority:
    - DIME if `remaining`>=10 and `!dime_empty`;
    - else NICKEL if `remaining`>=5 and `!nickel_empty`;
    - else no coin.
  - SELECT outcome: coin found, register the code and go to ISSUE. No coin, go to DONE (owed = `remaining`).
  - ISSUE: `coin_valid`=1 and `coin` stays stable until `coin_ready`. Empty-flag changes are ignored here. On handshake, subtract the coin value (10 or 5) from `remaining`. Go to DONE if the result is <5, else back to SELECT.
  - DONE: `done`=1 for one cycle and `owed` = `remaining`. Return to IDLE.
- A penny remainder (amount mod 5) is never paid and always appears in `owed`.
- If the dime hopper is empty, change is paid in nickels. If both hoppers are empty, the request ends with `owed` = the full unpaid balance.
- The subtraction cannot underflow: a coin is only selected when `remaining` >= its value.
- Reset mid-operation returns to IDLE immediately. Any coin in flight is abandoned and `remaining` is cleared.

## Timing
- Reset values:
  - `req_ready`=1 once `rst_n` is high (IDLE);
  - `coin_valid`=0, `coin`=PENNY (2'd0), `done`=0, `owed`=0.
- Accept at edge N: SELECT in cycle N+1, `coin_valid` high from cycle N+2.
- Each coin takes at least 2 cycles (SELECT + ISSUE). Coins are never back-to-back; `coin_valid` drops for exactly one cycle between coins.
- `coin_ready` while `coin_valid`=0 is ignored.
- `done` is asserted one cycle after the last coin handshake, or one cycle after a failing SELECT. `req_ready` goes high on the following cycle.
- Zero amount: IDLE→SELECT→DONE, `done` at N+2, `owed`=0, no coin.

## Configuration
- `CHANGE_QUARTER_EN` defined:
  - adds input `quarter_empty` (1 bit);
  - code 2'd3 = QUARTER (25 cents);
  - SELECT tries QUARTER first when `remaining`>=25 and `!quarter_empty`.
- `CHANGE_QUARTER_EN` undefined: no `quarter_empty` port, code 3 is never driven, and dimes have highest priority.

## Structure
- Shared package `vm_pkg`:
  - coin code constants PENNY/NICKEL/DIME/QUARTER;
  - coin value constants (5/10/25);
  - state typedef IDLE/SELECT/ISSUE/DONE.
- Sub-module `coin_select`: combinational picker (remaining + empty flags → found, code, value). Instantiated once; holds all `CHANGE_QUARTER_EN` logic except the port.

## Test plan
- Amount 35, no empties → coins DIME, DIME, DIME, NICKEL, then `done` with `owed`=0. Each coin is held through 3 cycles of `coin_ready`=0.
- Amount 23 → DIME, DIME, then `done` with `owed`=3. No PENNY is ever valid.
- Amount 20 with `dime_empty`=1 → four NICKELs, `owed`=0. Raise `dime_empty` during ISSUE of a DIME: the presented coin does not change.
- Amount 30 with `nickel_empty`=`dime_empty`=1 → no `coin_valid`, `done` at N+2 with `owed`=30.
- Assert `rst_n`=0 in ISSUE of the second coin of amount 50 → `coin_valid`=0 asynchronously. After release, `req_ready`=1 and amount 5 pays one NICKEL.
- With `CHANGE_QUARTER_EN`, amount 40 → QUARTER, DIME, NICKEL. With `quarter_empty`=1 → four DIMEs.
